raster_scan: RTL

Triangle traversal stage sitting directly upstream of the per-pixel edge-test unit (`ppu`). Accepts one triangle descriptor per handshake: screen-space bounding box, three edge-plane coefficient pairs, plane constants and flat colour. Walks every pixel of the bounding box in raster order and presents one `(x, y)` per cycle, with the held triangle data, on a valid/ready stream. `ppu` consumes that stream directly and decides inside/outside.

---
 rtl/gpu_pkg.sv | 39 +++
 rtl/raster_scan_if.sv | 40 ++++
 rtl/raster_walk.sv | 109 ++++++++++
 rtl/raster_scan.sv | 103 ++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU types: coordinate/product widths, triangle descriptor bundle, raster FSM states.
// Used by raster_scan and the downstream per-pixel edge-test unit.
package gpu_pkg;

    localparam int GPU_COORD_WIDTH = 16;
    localparam int GPU_COLOR_WIDTH = 16;

    typedef logic [GPU_COORD_WIDTH-1:0]   coord_t;
    typedef logic [2*GPU_COORD_WIDTH-1:0] mul_res_t;
    typedef logic [GPU_COLOR_WIDTH-1:0]   color_t;

    typedef struct packed {
        coord_t xmin;
        coord_t xmax;
        coord_t ymin;
        coord_t ymax;
    } bbox_t;

    typedef struct packed {
        coord_t   [2:0][1:0] coefs;
        mul_res_t [2:0]      consts;
    } tri_geom_t;

    typedef struct packed {
        bbox_t     box;
        tri_geom_t geom;
        color_t    color;
    } tri_desc_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } raster_state_e;

    function automatic logic box_empty(bbox_t b);
        return (b.xmin > b.xmax) || (b.ymin > b.ymax);
    endfunction

endpackage

// File: rtl/raster_scan_if.sv
// Triangle-descriptor input stream and pixel-beat output stream of raster_scan.
// master = producer of triangles / consumer of pixels, slave = raster_scan.
interface raster_scan_if;
    import gpu_pkg::*;

    logic     tri_valid;
    logic     tri_ready;
    coord_t   bbox_xmin;
    coord_t   bbox_xmax;
    coord_t   bbox_ymin;
    coord_t   bbox_ymax;
    coord_t   tri_coefs [3][2];
    mul_res_t tri_const [3];
    color_t   tri_color;

    logic     pix_valid;
    logic     pix_ready;
    coord_t   x;
    coord_t   y;
    coord_t   bound_coefs [3][2];
    mul_res_t bound_const [3];
    color_t   color;
    logic     pix_last;
    logic     busy;

    modport master (
        output tri_valid, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax,
               tri_coefs, tri_const, tri_color, pix_ready,
        input  tri_ready, pix_valid, x, y, bound_coefs, bound_const,
               color, pix_last, busy
    );

    modport slave (
        input  tri_valid, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax,
               tri_coefs, tri_const, tri_color, pix_ready,
        output tri_ready, pix_valid, x, y, bound_coefs, bound_const,
               color, pix_last, busy
    );

endinterface

// File: rtl/raster_walk.sv
// x/y pixel walker with equality-based end detection; RASTER_SERPENTINE_EN reverses odd rows.
// Latency: load/step take effect on the next edge; last_o is registered.
// Backpressure: only moves on step_i, otherwise holds every register.
module raster_walk #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         step_i,
    input  logic [W-1:0] xmin_i,
    input  logic [W-1:0] xmax_i,
    input  logic [W-1:0] ymin_i,
    input  logic [W-1:0] ymax_i,
    output logic [W-1:0] x_o,
    output logic [W-1:0] y_o,
    output logic         last_o,
    output logic         done_o
);

    logic [W-1:0] x_q, x_d, y_q, y_d;
    logic [W-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymax_q, ymax_d;
    logic         last_q, last_d;
    logic [W-1:0] xend;
    logic         at_xend, at_ymax;

`ifdef RASTER_SERPENTINE_EN
    logic dir_q, dir_d;
    assign xend = dir_q ? xmin_q : xmax_q;
`else
    assign xend = xmax_q;
`endif

    // Equality end tests keep a box touching 2^W-1 from ever wrapping.
    assign at_xend = (x_q == xend);
    assign at_ymax = (y_q == ymax_q);
    assign done_o  = at_xend && at_ymax;
    assign x_o     = x_q;
    assign y_o     = y_q;
    assign last_o  = last_q;

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        xmin_d = xmin_q;
        xmax_d = xmax_q;
        ymax_d = ymax_q;
        last_d = last_q;
`ifdef RASTER_SERPENTINE_EN
        dir_d  = dir_q;
`endif
        if (load_i) begin
            xmin_d = xmin_i;
            xmax_d = xmax_i;
            ymax_d = ymax_i;
            x_d    = xmin_i;
            y_d    = ymin_i;
            last_d = (xmin_i == xmax_i) && (ymin_i == ymax_i);
`ifdef RASTER_SERPENTINE_EN
            dir_d  = 1'b0;
`endif
        end else if (step_i) begin
            if (!at_xend) begin
`ifdef RASTER_SERPENTINE_EN
                x_d = dir_q ? x_q - W'(1) : x_q + W'(1);
`else
                x_d = x_q + W'(1);
`endif
                last_d = (x_d == xend) && at_ymax;
            end else if (!at_ymax) begin
                y_d = y_q + W'(1);
`ifdef RASTER_SERPENTINE_EN
                dir_d = !dir_q;
                x_d   = dir_q ? xmin_q : xmax_q;
`else
                x_d   = xmin_q;
`endif
                last_d = (xmin_q == xmax_q) && (y_d == ymax_q);
            end else begin
                last_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            xmin_q <= '0;
            xmax_q <= '0;
            ymax_q <= '0;
            last_q <= 1'b0;
`ifdef RASTER_SERPENTINE_EN
            dir_q  <= 1'b0;
`endif
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            xmin_q <= xmin_d;
            xmax_q <= xmax_d;
            ymax_q <= ymax_d;
            last_q <= last_d;
`ifdef RASTER_SERPENTINE_EN
            dir_q  <= dir_d;
`endif
        end
    end

endmodule

// File: rtl/raster_scan.sv
// Triangle traversal: walks the bounding box in raster order, one (x,y) beat per cycle (RASTER_SERPENTINE_EN: serpentine rows).
// Latency: descriptor accepted in cycle N -> first beat in N+1; one bubble between triangles.
// Backpressure: beats advance only on pix_valid && pix_ready; all outputs hold while stalled.
module raster_scan
    import gpu_pkg::*;
#(
    parameter int COORD_WIDTH = GPU_COORD_WIDTH,
    parameter int COLOR_WIDTH = GPU_COLOR_WIDTH
) (
    input logic         clk,
    input logic         rst_n,
    raster_scan_if.slave bus
);

    raster_state_e            state_q, state_d;
    tri_desc_t                desc;
    tri_geom_t                geom_q, geom_d;
    logic [COLOR_WIDTH-1:0]   color_q, color_d;
    logic                     load, step, done;

    always_comb begin
        desc.box.xmin = bus.bbox_xmin;
        desc.box.xmax = bus.bbox_xmax;
        desc.box.ymin = bus.bbox_ymin;
        desc.box.ymax = bus.bbox_ymax;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 2; j++) begin
                desc.geom.coefs[i][j] = bus.tri_coefs[i][j];
            end
            desc.geom.consts[i] = bus.tri_const[i];
        end
        desc.color = bus.tri_color;
    end

    // An empty box is handshaken in IDLE but never loaded, so it is silently dropped.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.tri_valid && !box_empty(desc.box)) begin
                    load    = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (bus.pix_ready) begin
                    step = 1'b1;
                    if (done) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
        geom_d  = load ? desc.geom  : geom_q;
        color_d = load ? desc.color : color_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            geom_q  <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            geom_q  <= geom_d;
            color_q <= color_d;
        end
    end

    raster_walk #(
        .W (COORD_WIDTH)
    ) u_walk (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .step_i (step),
        .xmin_i (desc.box.xmin),
        .xmax_i (desc.box.xmax),
        .ymin_i (desc.box.ymin),
        .ymax_i (desc.box.ymax),
        .x_o    (bus.x),
        .y_o    (bus.y),
        .last_o (bus.pix_last),
        .done_o (done)
    );

    assign bus.tri_ready = (state_q == IDLE);
    assign bus.pix_valid = (state_q == SCAN);
    assign bus.busy      = (state_q == SCAN);
    assign bus.color     = color_q;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 2; j++) begin
                bus.bound_coefs[i][j] = geom_q.coefs[i][j];
            end
            bus.bound_const[i] = geom_q.consts[i];
        end
    end

endmodule
